// File: rtl/image_tile_server_if.sv
// Host load stream and conv_pool read port of the image tile server.
interface image_tile_server_if #(
    parameter int unsigned AW = 16
);
    localparam int unsigned TW = 128;

    logic          load_valid;
    logic          load_ready;
    logic [TW-1:0] load_data;
    logic          reload;
    logic          image_valid;
    logic          input_re;
    logic [AW-1:0] input_addr;
    logic [TW-1:0] image_4x4_r;
    logic [TW-1:0] image_4x4_g;
    logic [TW-1:0] image_4x4_b;
    logic          rd_err;

    // Host / conv_pool side
    modport master (
        output load_valid, load_data, reload, input_re, input_addr,
        input  load_ready, image_valid, image_4x4_r, image_4x4_g, image_4x4_b, rd_err
    );

    // Tile server side
    modport slave (
        input  load_valid, load_data, reload, input_re, input_addr,
        output load_ready, image_valid, image_4x4_r, image_4x4_g, image_4x4_b, rd_err
    );
endinterface

// File: rtl/image_tile_server.sv
// Three-channel 4x4 tile store: streamed load, then fixed-latency reads for conv_pool.
module image_tile_server #(
    parameter int unsigned DEPTH  = 65025,
    parameter int unsigned AW     = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    image_tile_server_if.slave bus
);
    localparam int unsigned TW = 128;
    localparam int unsigned RW = 3 * TW;
    localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        LOAD_R,
        LOAD_G,
        LOAD_B,
        SERVE
    } state_e;

    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_lat
        $error("image_tile_server: RD_LAT must be 1 or 2");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load_ready_q, load_ready_d;
    logic          image_valid_q, image_valid_d;
    logic          xfer_c, last_c;
    logic          wr_r_c, wr_g_c, wr_b_c;

    logic [TW-1:0] mem_r [DEPTH];
    logic [TW-1:0] mem_g [DEPTH];
    logic [TW-1:0] mem_b [DEPTH];

    logic          addr_ok_c, rd_bad_c;
    logic [CW-1:0] rd_idx_c;
    logic [RW-1:0] rd_word_c;
    logic [RW-1:0] out_q;
    logic          rd_err_q;

    // Load FSM state, word counter and registered handshake status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= LOAD_R;
            cnt_q         <= '0;
            load_ready_q  <= 1'b0;
            image_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            load_ready_q  <= load_ready_d;
            image_valid_q <= image_valid_d;
        end
    end

    // Next state, counter advance and per-channel write strobes; reload wins over a transfer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_r_c  = 1'b0;
        wr_g_c  = 1'b0;
        wr_b_c  = 1'b0;
        last_c  = 1'b0;
        xfer_c  = bus.load_valid & load_ready_q & ~bus.reload;
        if (bus.reload) begin
            state_d = LOAD_R;
            cnt_d   = '0;
        end else if (xfer_c) begin
            last_c = (cnt_q == CW'(DEPTH - 1));
            cnt_d  = last_c ? '0 : cnt_q + CW'(1);
            case (state_q)
                LOAD_R: begin
                    wr_r_c = 1'b1;
                    if (last_c) state_d = LOAD_G;
                end
                LOAD_G: begin
                    wr_g_c = 1'b1;
                    if (last_c) state_d = LOAD_B;
                end
                LOAD_B: begin
                    wr_b_c = 1'b1;
                    if (last_c) state_d = SERVE;
                end
                SERVE: ;
            endcase
        end
        load_ready_d  = (state_d != SERVE);
        image_valid_d = (state_d == SERVE);
    end

    // Tile memories are written in address order and keep their contents through reset
    always_ff @(posedge clk) begin
        if (wr_r_c) mem_r[cnt_q] <= bus.load_data;
        if (wr_g_c) mem_g[cnt_q] <= bus.load_data;
        if (wr_b_c) mem_b[cnt_q] <= bus.load_data;
    end

    // Read lookup: early or out-of-range requests return an all-zero word
    always_comb begin
        addr_ok_c = (32'(bus.input_addr) < DEPTH);
        rd_bad_c  = ~image_valid_q | ~addr_ok_c;
        rd_idx_c  = addr_ok_c ? bus.input_addr[CW-1:0] : '0;
        rd_word_c = '0;
        if (!rd_bad_c) begin
            rd_word_c = {mem_r[rd_idx_c], mem_g[rd_idx_c], mem_b[rd_idx_c]};
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        // Single stage: the output word and sticky error update on the request edge
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                out_q    <= '0;
                rd_err_q <= 1'b0;
            end else if (bus.input_re) begin
                out_q <= rd_word_c;
                if (rd_bad_c) rd_err_q <= 1'b1;
            end
        end
    end else begin : g_lat2
        logic          s1_vld_q;
        logic          s1_bad_q;
        logic [RW-1:0] s1_word_q;

        // Two stages: lookup is registered first, error flag rises with the data
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1_vld_q  <= 1'b0;
                s1_bad_q  <= 1'b0;
                s1_word_q <= '0;
                out_q     <= '0;
                rd_err_q  <= 1'b0;
            end else begin
                s1_vld_q <= bus.input_re;
                if (bus.input_re) begin
                    s1_word_q <= rd_word_c;
                    s1_bad_q  <= rd_bad_c;
                end
                if (s1_vld_q) begin
                    out_q <= s1_word_q;
                    if (s1_bad_q) rd_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.load_ready  = load_ready_q;
    assign bus.image_valid = image_valid_q;
    assign bus.image_4x4_r = out_q[RW-1 -: TW];
    assign bus.image_4x4_g = out_q[2*TW-1 -: TW];
    assign bus.image_4x4_b = out_q[TW-1:0];
    assign bus.rd_err      = rd_err_q;

endmodule
